// File: rtl/fifo_write_packer_pkg.sv
// fifo_write_packer_pkg: shared FSM state, counter width helper and default geometry for the packer and FIFO datapath.
package fifo_write_packer_pkg;
  localparam int DEF_NUM_BIT = 4;
  localparam int DEF_PAR_WRITE = 2;
  typedef enum logic {FILL, FULL} state_e;
  function automatic int cnt_w(input int par_write);
    return $clog2(par_write + 1);
  endfunction
endpackage

// File: rtl/pack_lane_reg.sv
// pack_lane_reg: PAR_WRITE x NUM_BIT lane bank with indexed write, per-lane keep mask and synchronous clear.
module pack_lane_reg
  import fifo_write_packer_pkg::*;
#(
  parameter int NUM_BIT = DEF_NUM_BIT,
  parameter int PAR_WRITE = DEF_PAR_WRITE,
  parameter int IW = cnt_w(PAR_WRITE)
) (
  input  logic                         clk,
  input  logic                         clr_i,
  input  logic                         we_i,
  input  logic [IW-1:0]                idx_i,
  input  logic [NUM_BIT-1:0]           wdata_i,
  input  logic [PAR_WRITE-1:0]         keep_i,
  output logic [PAR_WRITE*NUM_BIT-1:0] data_o
);
  logic [PAR_WRITE*NUM_BIT-1:0] data_q, data_d;
  // A lane with keep_i low is zeroed unless it is the one being written.
  always_comb begin
    data_d = data_q;
    for (int l = 0; l < PAR_WRITE; l++)
      data_d[l*NUM_BIT +: NUM_BIT] = clr_i ? '0 :
                                     (we_i && idx_i == IW'(l)) ? wdata_i :
                                     keep_i[l] ? data_q[l*NUM_BIT +: NUM_BIT] : '0;
  end
  always_ff @(posedge clk) data_q <= data_d;
  assign data_o = data_q;
endmodule

// File: rtl/fifo_write_packer.sv
// fifo_write_packer: packs PAR_WRITE producer words into one FIFO write group; PACKER_FLUSH_EN adds flush/out_mask.
module fifo_write_packer
  import fifo_write_packer_pkg::*;
#(
  parameter int NUM_BIT = DEF_NUM_BIT,
  parameter int PAR_WRITE = DEF_PAR_WRITE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_BIT-1:0]             in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [PAR_WRITE*NUM_BIT-1:0]   out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
`ifdef PACKER_FLUSH_EN
  input  logic                           flush,
  output logic [PAR_WRITE-1:0]           out_mask,
`endif
  output logic [cnt_w(PAR_WRITE)-1:0]    fill_cnt
);
  localparam int CW = cnt_w(PAR_WRITE);
  localparam logic [CW-1:0] PW = CW'(PAR_WRITE);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, base, cnt_inc;
  logic acc, drain, done, flush_go, load;
  logic [PAR_WRITE-1:0] lo, keep;
  assign in_ready = !rst && (state_q == FILL || out_ready);
  assign acc = in_valid && in_ready;
  assign drain = state_q == FULL && out_ready;
  // On a drain cycle the next group starts from lane 0.
  assign base = state_q == FILL ? cnt_q : '0;
  assign cnt_inc = base + CW'(acc);
  assign done = cnt_inc == PW;
  always_comb begin
    lo = '0;
    for (int l = 0; l < PAR_WRITE; l++) lo[l] = CW'(l) < cnt_inc;
  end
`ifdef PACKER_FLUSH_EN
  assign flush_go = flush && state_q == FILL && cnt_inc != '0 && !done;
`else
  assign flush_go = 1'b0;
`endif
  assign keep = flush_go ? lo : '1;
  assign load = (state_q == FILL || drain) && (done || flush_go);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == FILL || drain) begin
      state_d = load ? FULL : FILL;
      cnt_d = load ? '0 : cnt_inc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef PACKER_FLUSH_EN
  logic [PAR_WRITE-1:0] mask_q, mask_d;
  assign mask_d = load ? keep : mask_q;
  always_ff @(posedge clk) mask_q <= rst ? '0 : mask_d;
  assign out_mask = mask_q;
`endif
  pack_lane_reg #(.NUM_BIT(NUM_BIT), .PAR_WRITE(PAR_WRITE), .IW(CW)) u_lanes (
    .clk    (clk),
    .clr_i  (rst),
    .we_i   (acc),
    .idx_i  (base),
    .wdata_i(in_data),
    .keep_i (keep),
    .data_o (out_data)
  );
  assign out_valid = state_q == FULL;
  assign fill_cnt = cnt_q;
endmodule
